// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: depth-generic load-use stall, redirect flush and EX operand forwarding.
// Define PIPE_HAZ_PERF_EN to add saturating stall/flush/retire counters.
module pipe_hazard_ctrl #(
   parameter int DEPTH = 3,
   parameter int RF_ADDRESS = 5,
   parameter int LOAD_READY = 2,
   parameter int CNT_W = 32,
   localparam int FW = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  id_valid,
   input  logic [RF_ADDRESS-1:0] id_rs1,
   input  logic [RF_ADDRESS-1:0] id_rs2,
   input  logic                  id_use_rs1,
   input  logic                  id_use_rs2,
   input  logic [RF_ADDRESS-1:0] id_rd,
   input  logic                  id_regwrite,
   input  logic                  id_memread,
   input  logic                  ex_br_taken,
   output logic                  stall,
   output logic                  flush_ifid,
   output logic                  bubble_idex,
   output logic [FW-1:0]         fwd_sel_a,
   output logic [FW-1:0]         fwd_sel_b,
   output logic [DEPTH-1:0]      stg_valid
`ifdef PIPE_HAZ_PERF_EN
   ,
   output logic [CNT_W-1:0]      perf_stall_cnt,
   output logic [CNT_W-1:0]      perf_flush_cnt,
   output logic [CNT_W-1:0]      perf_retire_cnt
`endif
);
   if (DEPTH < 2 || DEPTH > 8 || LOAD_READY < 1 || LOAD_READY >= DEPTH || CNT_W < 1)
      $error("pipe_hazard_ctrl: illegal parameters");
   logic [DEPTH-1:0] v, rw, mr, live;
   logic [DEPTH-1:0][RF_ADDRESS-1:0] rd;
   logic [RF_ADDRESS-1:0] ex_rs1, ex_rs2;
   logic stall_lu, fwd_bad, take;
   logic [FW-1:0] sel_a, sel_b;
   function automatic logic match(input logic l, input logic [RF_ADDRESS-1:0] r, input logic [RF_ADDRESS-1:0] s);
      return l && r == s;
   endfunction
   always_comb begin
      live = '0;
      for (int k = 0; k < DEPTH; k++)
         live[k] = v[k] & rw[k] & (|rd[k]);
   end
   always_comb begin
      stall_lu = 1'b0;
      for (int k = 0; k < LOAD_READY - 1; k++)
         stall_lu |= id_valid && mr[k] &&
                     ((id_use_rs1 && match(live[k], rd[k], id_rs1)) || (id_use_rs2 && match(live[k], rd[k], id_rs2)));
   end
   // Oldest-to-youngest scan so the youngest producer overwrites; young loads are unreachable and only flagged.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      fwd_bad = 1'b0;
      for (int k = DEPTH - 1; k >= 1; k--) begin
         if (match(live[k], rd[k], ex_rs1)) begin
            if (mr[k] && k < LOAD_READY) fwd_bad = 1'b1;
            else sel_a = FW'(k);
         end
         if (match(live[k], rd[k], ex_rs2)) begin
            if (mr[k] && k < LOAD_READY) fwd_bad = 1'b1;
            else sel_b = FW'(k);
         end
      end
   end
   assign stall = !reset && stall_lu && !ex_br_taken;
   assign bubble_idex = !reset && (stall_lu || ex_br_taken);
   assign flush_ifid = !reset && ex_br_taken;
   assign fwd_sel_a = reset ? '0 : sel_a;
   assign fwd_sel_b = reset ? '0 : sel_b;
   assign stg_valid = v;
   assign take = id_valid && !bubble_idex;
   // Unused sources are stored as x0 so they can never select a forward.
   always_ff @(posedge clk) begin
      if (reset) begin
         v <= '0;
         rw <= '0;
         mr <= '0;
         rd <= '0;
         ex_rs1 <= '0;
         ex_rs2 <= '0;
      end else begin
         v <= {v[DEPTH-2:0], take};
         rw <= {rw[DEPTH-2:0], take && id_regwrite};
         mr <= {mr[DEPTH-2:0], take && id_memread};
         rd <= {rd[DEPTH-2:0], {RF_ADDRESS{take}} & id_rd};
         ex_rs1 <= {RF_ADDRESS{take && id_use_rs1}} & id_rs1;
         ex_rs2 <= {RF_ADDRESS{take && id_use_rs2}} & id_rs2;
      end
   end
   always_ff @(posedge clk)
      if (!reset) assert (!fwd_bad);
`ifdef PIPE_HAZ_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_stall_cnt <= '0;
         perf_flush_cnt <= '0;
         perf_retire_cnt <= '0;
      end else begin
         perf_stall_cnt <= perf_stall_cnt + CNT_W'(stall && !(&perf_stall_cnt));
         perf_flush_cnt <= perf_flush_cnt + CNT_W'(ex_br_taken && !(&perf_flush_cnt));
         perf_retire_cnt <= perf_retire_cnt + CNT_W'(v[DEPTH-1] && !(&perf_retire_cnt));
      end
   end
`endif
endmodule
